// File: rtl/avmm_mem_responder.sv
// Avalon-MM responder backed by an on-chip 512-bit word memory.
// Handles single/burst reads and writes, pipelined read latency and waitrequest back-pressure.
module avmm_mem_responder #(
  parameter int unsigned ADDR_DEPTH  = 10,
  parameter int unsigned RD_LATENCY  = 4,
  parameter int unsigned MAX_PENDING = 8,
  parameter int unsigned WAIT_PERIOD = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           s_waitrequest,
  input  logic                           s_read,
  input  logic                           s_write,
  input  logic [63:0]                    s_address,
  input  logic [2:0]                     s_burstcount,
  input  logic [511:0]                   s_writedata,
  input  logic [63:0]                    s_byteenable,
  output logic [511:0]                   s_readdata,
  output logic                           s_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]   rd_pending,
  output logic                           err_addr,
  output logic                           err_proto
);

  localparam int unsigned AW    = ADDR_DEPTH;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned QW    = $clog2(MAX_PENDING);
  localparam int unsigned PW    = QW + 1;
  localparam int unsigned TW    = 16;
  localparam int unsigned SW    = (WAIT_PERIOD > 1) ? $clog2(WAIT_PERIOD) : 1;

  typedef enum logic {IDLE, WBURST} wstate_t;

  wstate_t         state, state_n;
  logic [AW-1:0]   wbase, wbase_n;
  logic [2:0]      wlen, wlen_n;
  logic [2:0]      widx, widx_n;
  logic            werr, werr_n;

  logic [511:0]    mem [DEPTH];

  logic [AW-1:0]   cmd_word_c;
  logic            cmd_oob_c;
  logic [2:0]      cmd_len_c;
  logic            accept_c;
  logic            stall_tick_c;
  logic [SW-1:0]   stall_cnt;

  logic            mem_we_c;
  logic [AW-1:0]   mem_wa_c;
  logic            rd_push_c;
  logic            set_err_addr_c;
  logic            set_err_proto_c;

  logic [AW-1:0]   q_base [MAX_PENDING];
  logic [2:0]      q_len  [MAX_PENDING];
  logic            q_oob  [MAX_PENDING];
  logic [TW-1:0]   q_time [MAX_PENDING];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [QW-1:0]   head_c;
  logic            head_ready_c;

  logic [TW-1:0]   cyc;
  logic            busy;
  logic [AW-1:0]   raddr;
  logic [2:0]      rleft;
  logic            roob;
  logic            issue_c;
  logic            beat_c;
  logic            last_c;
  logic [AW-1:0]   beat_word_c;
  logic            beat_oob_c;

  logic            unused_addr_bits;
  assign unused_addr_bits = ^s_address[5:0];

  // Command decode and handshake
  assign cmd_word_c    = s_address[AW+5:6];
  assign cmd_oob_c     = |s_address[63:AW+6];
  assign cmd_len_c     = (s_burstcount == 3'd0) ? 3'd1 : s_burstcount;
  assign s_waitrequest = reset | (rd_pending == PW'(MAX_PENDING)) | stall_tick_c
                         | ((state == WBURST) & s_read);
  assign accept_c      = (s_read | s_write) & ~s_waitrequest;

  // Free-running stress stall generator
  assign stall_tick_c = (WAIT_PERIOD != 0) && (stall_cnt == SW'(WAIT_PERIOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    stall_cnt <= '0;
    else if (stall_cnt == SW'(WAIT_PERIOD - 1))   stall_cnt <= '0;
    else                                          stall_cnt <= stall_cnt + SW'(1);
  end

  // Write burst FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wbase <= '0;
      wlen  <= '0;
      widx  <= '0;
      werr  <= 1'b0;
    end else begin
      state <= state_n;
      wbase <= wbase_n;
      wlen  <= wlen_n;
      widx  <= widx_n;
      werr  <= werr_n;
    end
  end

  // Command acceptance: write beats, read pushes, error flags
  always_comb begin
    state_n         = state;
    wbase_n         = wbase;
    wlen_n          = wlen;
    widx_n          = widx;
    werr_n          = werr;
    mem_we_c        = 1'b0;
    mem_wa_c        = wbase + AW'(widx);
    rd_push_c       = 1'b0;
    set_err_addr_c  = 1'b0;
    set_err_proto_c = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          set_err_addr_c = cmd_oob_c;
          if (s_write) begin
            wbase_n         = cmd_word_c;
            wlen_n          = cmd_len_c;
            widx_n          = 3'd1;
            werr_n          = cmd_oob_c;
            mem_we_c        = ~cmd_oob_c;
            mem_wa_c        = cmd_word_c;
            set_err_proto_c = s_read;
            if (cmd_len_c != 3'd1) state_n = WBURST;
          end else begin
            rd_push_c = 1'b1;
          end
        end
      end
      WBURST: begin
        // reads are held off here, so any accept is a write beat
        if (accept_c) begin
          mem_we_c = ~werr;
          widx_n   = widx + 3'd1;
          if (widx == wlen - 3'd1) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Byte-masked memory write port
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 64; b++) begin
        if (s_byteenable[b]) mem[mem_wa_c][b*8 +: 8] <= s_writedata[b*8 +: 8];
      end
    end
  end

  // Read command queue storage
  always_ff @(posedge clk) begin
    if (rd_push_c) begin
      q_base[wr_ptr[QW-1:0]] <= cmd_word_c;
      q_len[wr_ptr[QW-1:0]]  <= cmd_len_c;
      q_oob[wr_ptr[QW-1:0]]  <= cmd_oob_c;
      q_time[wr_ptr[QW-1:0]] <= cyc;
    end
  end

  // Head issues once its latency budget (minus the RAM cycle) has elapsed
  assign head_c       = rd_ptr[QW-1:0];
  assign head_ready_c = (wr_ptr != rd_ptr)
                        && ((cyc - q_time[head_c]) >= TW'(RD_LATENCY - 1));
  assign issue_c      = ~busy & head_ready_c;
  assign beat_c       = busy | issue_c;
  assign beat_word_c  = busy ? raddr : q_base[head_c];
  assign beat_oob_c   = busy ? roob  : q_oob[head_c];
  assign last_c       = busy ? (rleft == 3'd1) : (q_len[head_c] == 3'd1);

  // Read engine, response registers and sticky errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      busy            <= 1'b0;
      raddr           <= '0;
      rleft           <= '0;
      roob            <= 1'b0;
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
      rd_pending      <= '0;
      err_addr        <= 1'b0;
      err_proto       <= 1'b0;
    end else begin
      cyc <= cyc + TW'(1);
      if (rd_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (issue_c) begin
        rd_ptr <= rd_ptr + PW'(1);
        busy   <= (q_len[head_c] != 3'd1);
        raddr  <= q_base[head_c] + AW'(1);
        rleft  <= q_len[head_c] - 3'd1;
        roob   <= q_oob[head_c];
      end else if (busy) begin
        raddr <= raddr + AW'(1);
        rleft <= rleft - 3'd1;
        if (rleft == 3'd1) busy <= 1'b0;
      end
      s_readdatavalid <= beat_c;
      if (beat_c) s_readdata <= beat_oob_c ? {512{1'b1}} : mem[beat_word_c];
      rd_pending <= rd_pending + PW'(rd_push_c) - PW'(beat_c & last_c);
      err_addr   <= err_addr  | set_err_addr_c;
      err_proto  <= err_proto | set_err_proto_c;
    end
  end

endmodule

// File: tb/tb_avmm_mem_responder.sv
// Randomized scoreboard bench for avmm_mem_responder (WAIT_PERIOD=3 stress build).
module tb_avmm_mem_responder;

  localparam int unsigned L  = 4;
  localparam int unsigned MP = 8;
  localparam int unsigned WP = 3;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   s_waitrequest;
  logic                   s_read = 1'b0;
  logic                   s_write = 1'b0;
  logic [63:0]            s_address = '0;
  logic [2:0]             s_burstcount = '0;
  logic [511:0]           s_writedata = '0;
  logic [63:0]            s_byteenable = '0;
  logic [511:0]           s_readdata;
  logic                   s_readdatavalid;
  logic [$clog2(MP):0]    rd_pending;
  logic                   err_addr;
  logic                   err_proto;

  avmm_mem_responder #(
    .ADDR_DEPTH(10), .RD_LATENCY(L), .MAX_PENDING(MP), .WAIT_PERIOD(WP)
  ) dut (
    .clk(clk), .reset(reset), .s_waitrequest(s_waitrequest),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .rd_pending(rd_pending),
    .err_addr(err_addr), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: word memory, expected beats, outstanding read commands
  typedef struct { logic [511:0] data; int unsigned at; } beat_t;
  typedef struct { int unsigned acc; int unsigned last; } cmd_t;

  logic [511:0] mem_m [1024];
  beat_t        exp_q[$];
  cmd_t         cmd_q[$];
  int unsigned  rd_end = 0;
  int unsigned  r_edge = 0;
  int unsigned  wb_left = 0;
  int unsigned  wb_idx = 0;
  int unsigned  wb_base = 0;
  bit           wb_oob = 0;
  logic         exp_err_addr = 1'b0;
  logic         exp_err_proto = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Commands accepted by edge e whose final beat has not yet been delivered
  function automatic int pend(input int unsigned e);
    int n = 0;
    foreach (cmd_q[i]) if (cmd_q[i].acc <= e && cmd_q[i].last >= e + 2) n++;
    return n;
  endfunction

  task automatic model_accept(input logic rd, input logic wr, input logic [63:0] addr,
                              input logic [2:0] bc, input logic [511:0] wd,
                              input logic [63:0] be, input int unsigned a);
    int unsigned len;
    int unsigned first;
    int unsigned idx;
    bit oob;
    len = (bc == 3'd0) ? 1 : int'(bc);
    oob = |addr[63:16];
    if (wr) begin
      if (wb_left == 0) begin
        wb_oob  = oob;
        wb_base = int'(addr[15:6]);
        wb_left = len;
        wb_idx  = 0;
        if (oob) exp_err_addr = 1'b1;
        if (rd)  exp_err_proto = 1'b1;
      end
      idx = (wb_base + wb_idx) % 1024;
      if (!wb_oob)
        for (int b = 0; b < 64; b++) if (be[b]) mem_m[idx][b*8 +: 8] = wd[b*8 +: 8];
      wb_idx++;
      wb_left--;
    end else begin
      first = (a + L > rd_end + 1) ? a + L : rd_end + 1;
      if (oob) exp_err_addr = 1'b1;
      for (int j = 0; j < int'(len); j++) begin
        beat_t bt;
        idx     = (int'(addr[15:6]) + j) % 1024;
        bt.data = oob ? {512{1'b1}} : mem_m[idx];
        bt.at   = first + j;
        exp_q.push_back(bt);
      end
      cmd_q.push_back('{acc: a, last: first + len - 1});
      rd_end = first + len - 1;
    end
  endtask

  // Hold one command/beat until accepted; starts and ends just after a falling edge
  task automatic issue(input logic rd, input logic wr, input logic [63:0] addr,
                       input logic [2:0] bc, input logic [511:0] wd, input logic [63:0] be);
    int unsigned a;
    logic ew;
    bit done = 0;
    s_read = rd; s_write = wr; s_address = addr; s_burstcount = bc;
    s_writedata = wd; s_byteenable = be;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      a  = cyc + 1;
      ew = (pend(a - 1) >= int'(MP)) || (((a - r_edge - 1) % WP) == WP - 1)
           || (wb_left > 0 && rd);
      chk("waitrequest", s_waitrequest, ew);
      @(posedge clk);
      if (!s_waitrequest) begin
        model_accept(rd, wr, addr, bc, wd, be, a);
        done = 1;
      end
      @(negedge clk);
    end
    chk("accept_timeout", done, 1);
  endtask

  task automatic idle(input int n);
    s_read = 1'b0; s_write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // mode: 0 random data, 1 all-ones, 2 zeros; probe asserts a read mid-burst
  task automatic wr_burst(input logic [63:0] addr, input logic [2:0] bc, input logic [63:0] be,
                          input int mode, input bit probe);
    int n;
    logic [511:0] wd;
    n = (bc == 3'd0) ? 1 : int'(bc);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 16; k++) wd[k*32 +: 32] = $urandom();
      if (mode == 1) wd = {512{1'b1}};
      if (mode == 2) wd = '0;
      if (i == 1 && probe) begin
        s_read = 1'b1; s_write = 1'b0;
        #1 chk("wburst_read_wait", s_waitrequest, 1);
        @(negedge clk);
      end
      issue(1'b0, 1'b1, addr, (i == 0) ? bc : 3'($urandom()), wd, be);
    end
    idle(0);
  endtask

  task automatic rd_cmd(input logic [63:0] addr, input logic [2:0] bc);
    issue(1'b1, 1'b0, addr, bc, '0, '0);
  endtask

  task automatic drain();
    int t = 0;
    idle(0);
    while ((exp_q.size() != 0 || cmd_q.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_q.size() + cmd_q.size()), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; s_read = 1'b0; s_write = 1'b0;
    #1;
    chk("rst_valid", s_readdatavalid, 0);
    chk("rst_rdata", s_readdata, 0);
    chk("rst_pending", rd_pending, 0);
    chk("rst_wait", s_waitrequest, 1);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_proto", err_proto, 0);
    exp_q.delete(); cmd_q.delete();
    rd_end = 0; wb_left = 0; exp_err_addr = 1'b0; exp_err_proto = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    r_edge = cyc;
  endtask

  function automatic logic [63:0] rand_addr(input bit allow_oob);
    logic [63:0] a;
    a = (64'($urandom_range(0, 1023)) << 6) | 64'($urandom_range(0, 63));
    if (allow_oob && $urandom_range(0, 7) == 0) a[16 + $urandom_range(0, 47)] = 1'b1;
    return a;
  endfunction

  // Monitor: scoreboard of read beats plus per-cycle status outputs
  always @(negedge clk) begin : mon
    beat_t b;
    if (!reset) begin
      if (s_readdatavalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", s_readdatavalid, 0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", s_readdata, b.data);
          chk("beat_time", 512'(cyc + 1), 512'(b.at));
        end
      end else if (exp_q.size() != 0 && exp_q[0].at <= cyc + 1) begin
        b = exp_q.pop_front();
        chk("missing_beat", s_readdatavalid, 1);
      end
      chk("rd_pending", 512'(rd_pending), 512'(pend(cyc)));
      chk("err_addr", err_addr, exp_err_addr);
      chk("err_proto", err_proto, exp_err_proto);
      while (cmd_q.size() != 0 && cmd_q[0].last < cyc + 2) void'(cmd_q.pop_front());
    end
  end

  initial begin
    int t;
    @(negedge clk);
    do_reset();

    // Fill every word so all later readback is defined
    for (int w = 0; w < 1024; w += 7)
      wr_burst(64'(w) << 6, 3'((1024 - w) < 7 ? (1024 - w) : 7), '1, 0, 0);

    // Single write/read, latency and pending count
    wr_burst(64'h40, 3'd1, '1, 0, 0);
    rd_cmd(64'h40, 3'd1);
    drain();

    // Burst 4 write with a read probe, then burst 4 read
    wr_burst(64'h1000, 3'd4, '1, 0, 1);
    rd_cmd(64'h1000, 3'd4);
    drain();

    // Partial byte enable over an all-ones word
    wr_burst(64'h80, 3'd1, '1, 1, 0);
    wr_burst(64'h80, 3'd1, 64'hF, 2, 0);
    rd_cmd(64'h80, 3'd1);
    drain();

    // Nine burst-1 reads against eight pending slots
    for (int i = 0; i < 9; i++) rd_cmd(64'(i + 2) << 6, 3'd1);
    drain();

    // Out-of-range read and write
    rd_cmd(64'h1_0000_0000, 3'd2);
    drain();
    wr_burst(64'h1_0000_0000, 3'd1, '1, 0, 0);
    rd_cmd(64'h0, 3'd1);
    drain();

    // Simultaneous read and write: write wins
    issue(1'b1, 1'b1, 64'h200, 3'd1, {16{32'hA5A5_5A5A}}, '1);
    rd_cmd(64'h200, 3'd1);
    drain();

    // Randomized rounds: writes, then pipelined reads
    for (int r = 0; r < 14; r++) begin
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        wr_burst(rand_addr(1), 3'($urandom_range(0, 7)), {$urandom(), $urandom()}, 0, 0);
      for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
        rd_cmd(rand_addr(1), 3'($urandom_range(0, 7)));
        idle(int'($urandom_range(0, 2)));
      end
      drain();
    end

    // Reset in the middle of a read burst
    rd_cmd(64'h1000, 3'd7);
    idle(0);
    t = 0;
    while (!s_readdatavalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rd_started", s_readdatavalid, 1);
    @(posedge clk);
    #2;
    do_reset();
    idle(3);
    chk("post_rst_valid", s_readdatavalid, 0);

    // Memory survives reset
    rd_cmd(64'h1000, 3'd4);
    wr_burst(64'h3000, 3'd3, '1, 0, 0);
    drain();
    rd_cmd(64'h3000, 3'd3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
